// File: rtl/bomb_slot_scheduler.sv
// Bomb slot table: arbitrates P1/P2 placement requests, allocates slots,
// runs fuse/blast timers from the frame tick and serves a combinational read port.
module bomb_slot_scheduler #(
  parameter int NUM_BOMBS      = 6,
  parameter int MAX_PER_PLAYER = 3,
  parameter int FUSE_TICKS     = 120,
  parameter int BLAST_TICKS    = 30,
  parameter int COORD_W        = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 game_reset,
  input  logic                 tick,
  input  logic                 p1_place,
  input  logic [COORD_W-1:0]   p1_x,
  input  logic [COORD_W-1:0]   p1_y,
  input  logic                 p2_place,
  input  logic [COORD_W-1:0]   p2_x,
  input  logic [COORD_W-1:0]   p2_y,
  output logic                 p1_ack,
  output logic                 p1_nack,
  output logic                 p2_ack,
  output logic                 p2_nack,
  output logic [1:0]           p1_count,
  output logic [1:0]           p2_count,
  output logic [NUM_BOMBS-1:0] explode_mask,
  input  logic [2:0]           rd_id,
  output logic [1:0]           rd_state,
  output logic [COORD_W-1:0]   rd_x,
  output logic [COORD_W-1:0]   rd_y,
  output logic                 rd_owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BLAST = 2'd2} slot_t;

  localparam logic [7:0] FUSE_T  = 8'(FUSE_TICKS);
  localparam logic [7:0] BLAST_T = 8'(BLAST_TICKS);
  localparam logic [1:0] MAX_CNT = 2'(MAX_PER_PLAYER);
  localparam logic [3:0] NB      = 4'(NUM_BOMBS);

  function automatic logic tile_match(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                      input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    return (ax == bx) && (ay == by);
  endfunction

  slot_t              slot_state_r [NUM_BOMBS];
  logic [COORD_W-1:0] slot_x_r     [NUM_BOMBS];
  logic [COORD_W-1:0] slot_y_r     [NUM_BOMBS];
  logic               slot_owner_r [NUM_BOMBS];
  logic [7:0]         slot_timer_r [NUM_BOMBS];

  slot_t              state_next_s [NUM_BOMBS];
  logic [COORD_W-1:0] x_next_s     [NUM_BOMBS];
  logic [COORD_W-1:0] y_next_s     [NUM_BOMBS];
  logic               owner_next_s [NUM_BOMBS];
  logic [7:0]         timer_next_s [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] mask_next_s;
  logic [1:0]         cnt1_next_s, cnt2_next_s;

  logic               pend1_r, pend2_r, last_grant_r;
  logic [COORD_W-1:0] pend1_x_r, pend1_y_r, pend2_x_r, pend2_y_r;

  logic               req1_s, req2_s, serve1_s, serve2_s, grant_s, has_free_s, dup_s;
  logic [COORD_W-1:0] cx1_s, cy1_s, cx2_s, cy2_s, svc_x_s, svc_y_s;
  logic [1:0]         svc_cnt_s;
  logic [2:0]         free_idx_s;

  // A fresh pulse is serviceable in its own cycle; a held request uses latched coordinates.
  assign req1_s    = pend1_r | p1_place;
  assign req2_s    = pend2_r | p2_place;
  assign cx1_s     = pend1_r ? pend1_x_r : p1_x;
  assign cy1_s     = pend1_r ? pend1_y_r : p1_y;
  assign cx2_s     = pend2_r ? pend2_x_r : p2_x;
  assign cy2_s     = pend2_r ? pend2_y_r : p2_y;
  assign serve2_s  = req2_s & (~req1_s | ~last_grant_r);
  assign serve1_s  = req1_s & ~serve2_s;
  assign svc_x_s   = serve2_s ? cx2_s : cx1_s;
  assign svc_y_s   = serve2_s ? cy2_s : cy1_s;
  assign svc_cnt_s = serve2_s ? p2_count : p1_count;
  assign grant_s   = (serve1_s | serve2_s) & has_free_s & ~dup_s & (svc_cnt_s != MAX_CNT);

  // Scan the registered table for the lowest idle slot and a same-tile occupant.
  always_comb begin
    has_free_s = 1'b0;
    free_idx_s = 3'd0;
    dup_s      = 1'b0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      has_free_s = has_free_s | (slot_state_r[i] == IDLE);
      free_idx_s = (slot_state_r[i] == IDLE) ? 3'(i) : free_idx_s;
      dup_s      = dup_s | ((slot_state_r[i] != IDLE) &
                            tile_match(slot_x_r[i], slot_y_r[i], svc_x_s, svc_y_s));
    end
  end

  // Next slot table: timer progression, then allocation of the granted slot, then counts.
  always_comb begin
    mask_next_s = '0;
    cnt1_next_s = 2'd0;
    cnt2_next_s = 2'd0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      state_next_s[i] = slot_state_r[i];
      x_next_s[i]     = slot_x_r[i];
      y_next_s[i]     = slot_y_r[i];
      owner_next_s[i] = slot_owner_r[i];
      timer_next_s[i] = slot_timer_r[i];
      if (tick) begin
        case (slot_state_r[i])
          ARMED: begin
            if (slot_timer_r[i] == 8'd1) begin
              state_next_s[i] = BLAST;
              timer_next_s[i] = BLAST_T;
              mask_next_s[i]  = 1'b1;
            end else begin
              timer_next_s[i] = slot_timer_r[i] - 8'd1;
            end
          end
          BLAST: begin
            state_next_s[i] = (slot_timer_r[i] == 8'd1) ? IDLE : BLAST;
            timer_next_s[i] = slot_timer_r[i] - 8'd1;
          end
          IDLE:    state_next_s[i] = IDLE;
          default: state_next_s[i] = IDLE;
        endcase
      end else begin
        timer_next_s[i] = slot_timer_r[i];
      end
      // The granted slot is idle in the registered table, so the tick never touched it.
      if (grant_s && (free_idx_s == 3'(i))) begin
        state_next_s[i] = ARMED;
        timer_next_s[i] = FUSE_T;
        x_next_s[i]     = svc_x_s;
        y_next_s[i]     = svc_y_s;
        owner_next_s[i] = serve2_s;
      end else begin
        owner_next_s[i] = owner_next_s[i];
      end
      cnt1_next_s = cnt1_next_s + {1'b0, (state_next_s[i] != IDLE) & ~owner_next_s[i]};
      cnt2_next_s = cnt2_next_s + {1'b0, (state_next_s[i] != IDLE) &  owner_next_s[i]};
    end
  end

  // State registers; game_reset clears everything synchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset || game_reset) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        slot_state_r[i] <= IDLE;
        slot_x_r[i]     <= '0;
        slot_y_r[i]     <= '0;
        slot_owner_r[i] <= 1'b0;
        slot_timer_r[i] <= 8'd0;
      end
      pend1_r <= 1'b0;  pend1_x_r <= '0;  pend1_y_r <= '0;
      pend2_r <= 1'b0;  pend2_x_r <= '0;  pend2_y_r <= '0;
      last_grant_r <= 1'b1;
      p1_ack <= 1'b0;  p1_nack <= 1'b0;  p2_ack <= 1'b0;  p2_nack <= 1'b0;
      p1_count <= 2'd0;  p2_count <= 2'd0;
      explode_mask <= '0;
    end else begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        slot_state_r[i] <= state_next_s[i];
        slot_x_r[i]     <= x_next_s[i];
        slot_y_r[i]     <= y_next_s[i];
        slot_owner_r[i] <= owner_next_s[i];
        slot_timer_r[i] <= timer_next_s[i];
      end
      pend1_r   <= serve1_s ? 1'b0 : (pend1_r | p1_place);
      pend2_r   <= serve2_s ? 1'b0 : (pend2_r | p2_place);
      pend1_x_r <= (p1_place & ~pend1_r) ? p1_x : pend1_x_r;
      pend1_y_r <= (p1_place & ~pend1_r) ? p1_y : pend1_y_r;
      pend2_x_r <= (p2_place & ~pend2_r) ? p2_x : pend2_x_r;
      pend2_y_r <= (p2_place & ~pend2_r) ? p2_y : pend2_y_r;
      last_grant_r <= (req1_s & req2_s) ? serve2_s : last_grant_r;
      p1_ack   <= serve1_s &  grant_s;
      p1_nack  <= serve1_s & ~grant_s;
      p2_ack   <= serve2_s &  grant_s;
      p2_nack  <= serve2_s & ~grant_s;
      p1_count <= cnt1_next_s;
      p2_count <= cnt2_next_s;
      explode_mask <= mask_next_s;
    end
  end

  // Drawing read port; ids beyond the table read as an empty slot.
  always_comb begin
    if ({1'b0, rd_id} < NB) begin
      rd_state = slot_state_r[rd_id];
      rd_x     = slot_x_r[rd_id];
      rd_y     = slot_y_r[rd_id];
      rd_owner = slot_owner_r[rd_id];
    end else begin
      rd_state = 2'd0;
      rd_x     = '0;
      rd_y     = '0;
      rd_owner = 1'b0;
    end
  end

endmodule

// File: tb/tb_bomb_slot_scheduler.sv
// Bench for bomb_slot_scheduler: directed vector table, corner-case sequences and
// randomized traffic, all checked against a slot-list reference model.
module tb_bomb_slot_scheduler;
  localparam int NB = 6, MAXP = 3, FUSE = 120, BLAST = 30, CW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1, game_reset = 1'b0, tick = 1'b0;
  logic p1_place = 1'b0, p2_place = 1'b0;
  logic [CW-1:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
  logic p1_ack, p1_nack, p2_ack, p2_nack;
  logic [1:0] p1_count, p2_count;
  logic [NB-1:0] explode_mask;
  logic [2:0] rd_id = 3'd0;
  logic [1:0] rd_state;
  logic [CW-1:0] rd_x, rd_y;
  logic rd_owner;

  bomb_slot_scheduler dut (
    .clock(clock), .reset(reset), .game_reset(game_reset), .tick(tick),
    .p1_place(p1_place), .p1_x(p1_x), .p1_y(p1_y),
    .p2_place(p2_place), .p2_x(p2_x), .p2_y(p2_y),
    .p1_ack(p1_ack), .p1_nack(p1_nack), .p2_ack(p2_ack), .p2_nack(p2_nack),
    .p1_count(p1_count), .p2_count(p2_count), .explode_mask(explode_mask),
    .rd_id(rd_id), .rd_state(rd_state), .rd_x(rd_x), .rd_y(rd_y), .rd_owner(rd_owner)
  );

  always #10 clock = ~clock;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of slots with a remaining-lifetime counter.
  int m_st[NB], m_x[NB], m_y[NB], m_ow[NB], m_left[NB];
  bit m_pend[2];
  int m_px[2], m_py[2], m_last, m_ack[2], m_nack[2], m_mask;

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) begin
      m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_ow[i] = 0; m_left[i] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0; m_px[p] = 0; m_py[p] = 0; m_ack[p] = 0; m_nack[p] = 0;
    end
    m_last = 1;
    m_mask = 0;
  endfunction

  function automatic int mcount(input int p);
    int n = 0;
    for (int i = 0; i < NB; i++) if (m_st[i] != 0 && m_ow[i] == p) n++;
    return n;
  endfunction

  function automatic void model_step();
    int pl[2], ix[2], iy[2], cx[2], cy[2];
    int w, held, free_slot;
    bit rq[2], dup, grant;
    pl[0] = int'(p1_place); ix[0] = int'(p1_x); iy[0] = int'(p1_y);
    pl[1] = int'(p2_place); ix[1] = int'(p2_x); iy[1] = int'(p2_y);
    for (int p = 0; p < 2; p++) begin m_ack[p] = 0; m_nack[p] = 0; end
    m_mask = 0;
    if (game_reset) begin model_clear(); return; end
    for (int p = 0; p < 2; p++) begin
      rq[p] = m_pend[p] || (pl[p] != 0);
      cx[p] = m_pend[p] ? m_px[p] : ix[p];
      cy[p] = m_pend[p] ? m_py[p] : iy[p];
    end
    w = -1;
    if (rq[0] && rq[1]) begin w = 1 - m_last; m_last = w; end
    else if (rq[0]) w = 0;
    else if (rq[1]) w = 1;
    grant = 0; free_slot = -1;
    if (w >= 0) begin
      held = 0; dup = 0;
      for (int i = 0; i < NB; i++) begin
        if (m_st[i] != 0) begin
          if (m_ow[i] == w) held++;
          if (m_x[i] == cx[w] && m_y[i] == cy[w]) dup = 1;
        end else if (free_slot < 0) free_slot = i;
      end
      grant = (held < MAXP) && (free_slot >= 0) && !dup;
      if (grant) m_ack[w] = 1; else m_nack[w] = 1;
    end
    if (tick) begin
      for (int i = 0; i < NB; i++) begin
        if (m_st[i] != 0) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            if (m_st[i] == 1) begin m_st[i] = 2; m_left[i] = BLAST; m_mask |= (1 << i); end
            else m_st[i] = 0;
          end
        end
      end
    end
    if (grant) begin
      m_st[free_slot] = 1; m_left[free_slot] = FUSE;
      m_x[free_slot] = cx[w]; m_y[free_slot] = cy[w]; m_ow[free_slot] = w;
    end
    for (int p = 0; p < 2; p++) begin
      if (p == w) m_pend[p] = 0;
      else if (pl[p] != 0 && !m_pend[p]) begin m_pend[p] = 1; m_px[p] = ix[p]; m_py[p] = iy[p]; end
    end
  endfunction

  task automatic check_read(input int id);
    rd_id = 3'(id);
    #1;
    if (id < NB) begin
      chk("rd_state", rd_state, m_st[id]);
      chk("rd_x", rd_x, m_x[id]);
      chk("rd_y", rd_y, m_y[id]);
      chk("rd_owner", rd_owner, m_ow[id]);
    end else begin
      chk("rd_state_oob", rd_state, 0);
      chk("rd_x_oob", rd_x, 0);
      chk("rd_y_oob", rd_y, 0);
      chk("rd_owner_oob", rd_owner, 0);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    chk("p1_ack", p1_ack, m_ack[0]);
    chk("p1_nack", p1_nack, m_nack[0]);
    chk("p2_ack", p2_ack, m_ack[1]);
    chk("p2_nack", p2_nack, m_nack[1]);
    chk("p1_count", p1_count, mcount(0));
    chk("p2_count", p2_count, mcount(1));
    chk("explode_mask", explode_mask, m_mask);
    check_read($urandom_range(0, 7));
    p1_place = 1'b0; p2_place = 1'b0; tick = 1'b0; game_reset = 1'b0;
  endtask

  task automatic rd_expect(input int id, input int st, input int x, input int y, input int ow);
    rd_id = 3'(id);
    #1;
    chk("slot_state", rd_state, st);
    chk("slot_x", rd_x, x);
    chk("slot_y", rd_y, y);
    chk("slot_owner", rd_owner, ow);
  endtask

  task automatic put1(input int x, input int y);
    p1_place = 1'b1; p1_x = CW'(x); p1_y = CW'(y);
  endtask

  task automatic put2(input int x, input int y);
    p2_place = 1'b1; p2_x = CW'(x); p2_y = CW'(y);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_clear();
    for (int i = 0; i < NB; i++) begin
      rd_id = 3'(i);
      #1;
      chk("reset_state", rd_state, 0);
    end
    chk("reset_p1_count", p1_count, 0);
    chk("reset_p2_count", p2_count, 0);
    chk("reset_pulses", {p1_ack, p1_nack, p2_ack, p2_nack}, 0);
    chk("reset_mask", explode_mask, 0);
    reset = 1'b0;
  endtask

  typedef struct {
    bit pl1; int x1; int y1;
    bit pl2; int x2; int y2;
    int a1; int n1; int a2; int n2; int c1; int c2;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 3, 5,   0, 0, 0,    1, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 2, 2,   1, 2, 2,    1, 0, 0, 0, 2, 0};
    tbl[2]  = '{0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 2, 0};
    tbl[3]  = '{1, 1, 1,   1, 4, 4,    0, 0, 1, 0, 2, 1};
    tbl[4]  = '{0, 0, 0,   0, 0, 0,    1, 0, 0, 0, 3, 1};
    tbl[5]  = '{1, 6, 6,   0, 0, 0,    0, 1, 0, 0, 3, 1};
    tbl[6]  = '{0, 0, 0,   1, 7, 7,    0, 0, 1, 0, 3, 2};
    tbl[7]  = '{0, 0, 0,   1, 8, 8,    0, 0, 1, 0, 3, 3};
    tbl[8]  = '{0, 0, 0,   1, 9, 9,    0, 0, 0, 1, 3, 3};
    tbl[9]  = '{1, 10, 10, 0, 0, 0,    0, 1, 0, 0, 3, 3};
    tbl[10] = '{1, 11, 11, 1, 12, 12,  0, 1, 0, 0, 3, 3};
    tbl[11] = '{0, 0, 0,   1, 13, 13,  0, 0, 0, 1, 3, 3};
    tbl[12] = '{0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 3, 3};

    do_reset();

    // Arbitration, limits and full table from a fresh reset.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pl1) put1(tbl[i].x1, tbl[i].y1);
      if (tbl[i].pl2) put2(tbl[i].x2, tbl[i].y2);
      step();
      chk($sformatf("vec%0d_p1_ack", i), p1_ack, tbl[i].a1);
      chk($sformatf("vec%0d_p1_nack", i), p1_nack, tbl[i].n1);
      chk($sformatf("vec%0d_p2_ack", i), p2_ack, tbl[i].a2);
      chk($sformatf("vec%0d_p2_nack", i), p2_nack, tbl[i].n2);
      chk($sformatf("vec%0d_p1_count", i), p1_count, tbl[i].c1);
      chk($sformatf("vec%0d_p2_count", i), p2_count, tbl[i].c2);
    end
    rd_expect(2, 1, 4, 4, 1);
    rd_expect(3, 1, 1, 1, 0);

    // A freed middle slot is reused before higher ones.
    game_reset = 1'b1; step();
    put1(1, 0); step();
    put1(2, 0); step();
    put2(3, 0); step();
    repeat (100) begin tick = 1'b1; step(); end
    put2(4, 0); step();
    rd_expect(3, 1, 4, 0, 1);
    repeat (50) begin tick = 1'b1; step(); end
    rd_expect(2, 0, 3, 0, 1);
    put1(5, 0); step();
    put1(6, 0); step();
    put1(7, 0); step();
    rd_expect(2, 1, 7, 0, 0);
    chk("reuse_p1_count", p1_count, 3);

    // Grant coinciding with a tick: full fuse, then exact blast length.
    game_reset = 1'b1; step();
    put1(3, 5); tick = 1'b1; step();
    chk("basic_ack", p1_ack, 1);
    chk("basic_count", p1_count, 1);
    rd_expect(0, 1, 3, 5, 0);
    for (int t = 1; t < FUSE; t++) begin
      tick = 1'b1; step();
      chk("basic_no_early_blast", explode_mask, 0);
    end
    tick = 1'b1; step();
    chk("basic_explode", explode_mask, 6'b000001);
    rd_expect(0, 2, 3, 5, 0);
    step();
    chk("basic_explode_pulse", explode_mask, 0);
    repeat (BLAST - 1) begin tick = 1'b1; step(); end
    rd_expect(0, 2, 3, 5, 0);
    tick = 1'b1; step();
    rd_expect(0, 0, 3, 5, 0);
    chk("basic_count_end", p1_count, 0);

    // Tied pair explodes on the same tick.
    game_reset = 1'b1; step();
    put1(1, 1); put2(2, 2); step();
    step();
    repeat (FUSE - 1) begin tick = 1'b1; step(); end
    tick = 1'b1; step();
    chk("pair_explode", explode_mask, 6'b000011);

    // game_reset wins over a tick that would have detonated.
    game_reset = 1'b1; step();
    put1(1, 1); step();
    put1(2, 2); step();
    put2(3, 3); step();
    repeat (FUSE - 1) begin tick = 1'b1; step(); end
    game_reset = 1'b1; tick = 1'b1; step();
    chk("greset_mask", explode_mask, 0);
    chk("greset_counts", {p1_count, p2_count}, 0);
    for (int i = 0; i < 3; i++) rd_expect(i, 0, 0, 0, 0);
    step();
    chk("greset_mask_after", explode_mask, 0);

    // Asynchronous reset with three armed slots.
    put1(1, 1); step();
    put1(2, 2); step();
    put2(3, 3); step();
    chk("pre_reset_p2_count", p2_count, 1);
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) put1($urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) put2($urandom_range(0, 3), $urandom_range(0, 3));
      tick = 1'($urandom_range(0, 1));
      game_reset = ($urandom_range(0, 499) == 0);
      step();
    end
    for (int i = 0; i < 8; i++) check_read(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
